// File: rtl/join_merge_pkg.sv
// Shared constants and types for the hash-join result merger.
// Macro JOIN_MERGE_COUNT_EN (see join_result_merger) enables the delivered-result counter.
package join_merge_pkg;

   localparam int LANES      = 8;
   localparam int LANE_IDX_W = 3;

   typedef logic [127:0]           join_result_t;
   typedef logic [LANE_IDX_W-1:0]  lane_idx_t;

endpackage

// File: rtl/join_lane_fifo.sv
// Per-lane synchronous FIFO using read/write pointers with an extra wrap bit.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module join_lane_fifo
   import join_merge_pkg::*;
#(
   parameter int DATA_W = 128,
   parameter int DEPTH  = 16
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              i_push,
   input  logic              i_pop,
   input  logic [DATA_W-1:0] i_data,
   output logic [DATA_W-1:0] o_data,
   output logic              o_full,
   output logic              o_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [AW:0]       r_wr_ptr;
   logic [AW:0]       r_rd_ptr;
   logic              w_full;
   logic              w_empty;
   logic              w_wr_en;
   logic              w_rd_en;

   // Same index with different wrap bits means the writer has lapped the reader.
   assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_wr_en = i_push && (!w_full || i_pop);
   assign w_rd_en = i_pop && !w_empty;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
   end

   assign o_data  = r_mem[r_rd_ptr[AW-1:0]];
   assign o_full  = w_full;
   assign o_empty = w_empty;

endmodule

// File: rtl/join_result_merger.sv
// Merges eight valid-only join result lanes into one ready/valid stream via round-robin.
// Define JOIN_MERGE_COUNT_EN to build the result_count handshake counter (else tied to 0).
module join_result_merger
   import join_merge_pkg::*;
#(
   parameter int DATA_W     = 128,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          clk,
   input  logic                          resetn,
   input  logic [LANES-1:0][DATA_W-1:0]  in_data,
   input  logic [LANES-1:0]              in_valid,
   output logic [DATA_W-1:0]             out_data,
   output lane_idx_t                     out_lane,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [LANES-1:0]              overflow,
   output logic                          drained,
   output logic [31:0]                   result_count
);

   // Output handshake: a beat transfers on a cycle where out_valid && out_ready;
   // out_data/out_lane are held stable while out_valid && !out_ready.

   logic [DATA_W-1:0] w_head [LANES];
   logic [LANES-1:0]  w_empty;
   logic [LANES-1:0]  w_full;
   logic [LANES-1:0]  w_pop;
   logic              w_grant_valid;
   lane_idx_t         w_grant_idx;
   logic              w_load;

   logic [DATA_W-1:0] r_out_data;
   lane_idx_t         r_out_lane;
   logic              r_out_valid;
   lane_idx_t         r_ptr;
   logic [LANES-1:0]  r_overflow;

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      join_lane_fifo #(
         .DATA_W (DATA_W),
         .DEPTH  (FIFO_DEPTH)
      ) u_fifo (
         .clk     (clk),
         .resetn  (resetn),
         .i_push  (in_valid[g]),
         .i_pop   (w_pop[g]),
         .i_data  (in_data[g]),
         .o_data  (w_head[g]),
         .o_full  (w_full[g]),
         .o_empty (w_empty[g])
      );
   end

   // First non-empty lane scanning from r_ptr upwards, modulo LANES.
   always_comb begin
      lane_idx_t v_scan;
      w_grant_valid = 1'b0;
      w_grant_idx   = '0;
      v_scan        = '0;
      for (int k = 0; k < LANES; k++) begin
         v_scan = r_ptr + lane_idx_t'(k);
         if (!w_grant_valid && !w_empty[v_scan]) begin
            w_grant_valid = 1'b1;
            w_grant_idx   = v_scan;
         end
      end
   end

   assign w_load = (!r_out_valid || out_ready) && w_grant_valid;

   always_comb begin
      w_pop = '0;
      if (w_load) w_pop[w_grant_idx] = 1'b1;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_out_data  <= '0;
         r_out_lane  <= '0;
         r_out_valid <= 1'b0;
         r_ptr       <= '0;
         r_overflow  <= '0;
      end else begin
         if (w_load) begin
            r_out_data  <= w_head[w_grant_idx];
            r_out_lane  <= w_grant_idx;
            r_out_valid <= 1'b1;
            r_ptr       <= w_grant_idx + lane_idx_t'(1);
         end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
         end
         // A write into a full lane is only lost when that lane is not popped.
         r_overflow <= r_overflow | (in_valid & w_full & ~w_pop);
      end
   end

`ifdef JOIN_MERGE_COUNT_EN
   logic [31:0] r_count;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_count <= '0;
      end else if (r_out_valid && out_ready) begin
         r_count <= r_count + 32'd1;
      end
   end

   assign result_count = r_count;
`else
   assign result_count = 32'd0;
`endif

   assign out_data  = r_out_data;
   assign out_lane  = r_out_lane;
   assign out_valid = r_out_valid;
   assign overflow  = r_overflow;
   assign drained   = (&w_empty) && !r_out_valid;

endmodule

// File: tb/tb_join_result_merger.sv
// Directed bench for join_result_merger: linear steps, immediate-assertion checks.
module tb_join_result_merger;
   import join_merge_pkg::*;

   localparam int DATA_W = 128;
   localparam int W      = DATA_W + LANE_IDX_W;

   logic                          clk;
   logic                          resetn;
   logic [LANES-1:0][DATA_W-1:0]  in_data;
   logic [LANES-1:0]              in_valid;
   logic [DATA_W-1:0]             out_data;
   lane_idx_t                     out_lane;
   logic                          out_valid;
   logic                          out_ready;
   logic [LANES-1:0]              overflow;
   logic                          drained;
   logic [31:0]                   result_count;

   logic [W-1:0] exp_q[$];
   int n_vec = 0;
   int n_err = 0;

   join_result_merger #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (16)
   ) dut (
      .clk          (clk),
      .resetn       (resetn),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .out_data     (out_data),
      .out_lane     (out_lane),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .overflow     (overflow),
      .drained      (drained),
      .result_count (result_count)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      in_valid = '0;
      in_data  = '0;
      resetn   = 1'b0;
      tick();
      tick();
      resetn   = 1'b1;
   endtask

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_count(input logic [31:0] n);
`ifdef JOIN_MERGE_COUNT_EN
      return n;
`else
      return 32'd0 & n;
`endif
   endfunction

   task automatic expect_beat(input logic [LANE_IDX_W-1:0] lane, input logic [DATA_W-1:0] data);
      exp_q.push_back({lane, data});
   endtask

   // Compares the presented beat against the head of the expected queue.
   task automatic check_beat(input string tag);
      logic [W-1:0] exp;
      check({tag, "_valid"}, W'(out_valid), W'(1));
      if (exp_q.size() == 0) begin
         n_vec++;
         n_err++;
         $error("FAIL %s_queue observed=beat expected=none", tag);
      end else begin
         exp = exp_q.pop_front();
         check(tag, {out_lane, out_data}, exp);
      end
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      in_valid  = '0;
      in_data   = '0;
      out_ready = 1'b0;
      resetn    = 1'b0;
      #2;
      check("rst_out_valid", W'(out_valid), W'(0));
      check("rst_out_data",  W'(out_data),  W'(0));
      check("rst_out_lane",  W'(out_lane),  W'(0));
      check("rst_overflow",  W'(overflow),  W'(0));
      check("rst_count",     W'(result_count), W'(0));
      check("rst_drained",   W'(drained),   W'(1));
      tick();
      resetn = 1'b1;
      tick();

      // Single beat on lane 4: visible two edges after it is sampled.
      out_ready   = 1'b1;
      in_valid    = 8'h10;
      in_data[4]  = 128'hA5;
      tick();
      in_valid    = '0;
      check("single_early_valid", W'(out_valid), W'(0));
      check("single_busy",        W'(drained),   W'(0));
      tick();
      expect_beat(3'd4, 128'hA5);
      check_beat("single_beat");
      tick();
      check("single_done_valid", W'(out_valid), W'(0));
      check("single_hold_data",  W'(out_data),  W'(128'hA5));
      check("single_drained",    W'(drained),   W'(1));
      check("single_count",      W'(result_count), W'(exp_count(32'd1)));

      // All lanes at once: delivered 0..7 back to back.
      do_reset();
      out_ready = 1'b1;
      in_valid  = 8'hFF;
      for (int i = 0; i < LANES; i++) in_data[i] = DATA_W'(i);
      tick();
      in_valid = '0;
      tick();
      for (int i = 0; i < LANES; i++) begin
         expect_beat(3'(i), DATA_W'(i));
         check_beat($sformatf("burst_%0d", i));
         tick();
      end
      check("burst_end_valid", W'(out_valid), W'(0));

      // Lanes 0 and 5 streaming: grants alternate 0,5,0,5.
      do_reset();
      out_ready = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         in_valid   = 8'h21;
         in_data[0] = DATA_W'(16'h0100 + c);
         in_data[5] = DATA_W'(16'h0500 + c);
         tick();
         if (c >= 2) begin
            if (c % 2 == 0) expect_beat(3'd0, DATA_W'(16'h0100 + c / 2));
            else            expect_beat(3'd5, DATA_W'(16'h0500 + (c - 1) / 2));
            check_beat($sformatf("fair_%0d", c));
         end
      end
      in_valid = '0;
      check("fair_overflow", W'(overflow), W'(0));

      // Backpressure: presented beat stays put, then everything drains once.
      do_reset();
      out_ready  = 1'b0;
      in_valid   = 8'h44;
      in_data[2] = 128'h21;
      in_data[6] = 128'h61;
      tick();
      in_valid   = 8'h04;
      in_data[2] = 128'h22;
      tick();
      in_data[2] = 128'h23;
      tick();
      in_valid   = '0;
      expect_beat(3'd2, 128'h21);
      expect_beat(3'd6, 128'h61);
      expect_beat(3'd2, 128'h22);
      expect_beat(3'd2, 128'h23);
      for (int c = 0; c < 10; c++) begin
         check($sformatf("bp_hold_%0d", c), {out_valid, out_lane, out_data[DATA_W-2:0]},
               {1'b1, exp_q[0][W-1:DATA_W], exp_q[0][DATA_W-2:0]});
         tick();
      end
      out_ready = 1'b1;
      for (int j = 0; j < 4; j++) begin
         check_beat($sformatf("bp_drain_%0d", j));
         tick();
      end
      check("bp_end_valid", W'(out_valid), W'(0));

      // Overflow: 18 writes into lane 3 while stalled; the 18th is dropped.
      do_reset();
      out_ready = 1'b0;
      for (int v = 1; v <= 18; v++) begin
         in_valid   = 8'h08;
         in_data[3] = DATA_W'(v);
         tick();
         if (v == 17) check("ovf_before", W'(overflow), W'(0));
         if (v == 18) check("ovf_after",  W'(overflow), W'(8'h08));
      end
      in_valid = '0;
      for (int v = 1; v <= 17; v++) expect_beat(3'd3, DATA_W'(v));
      out_ready = 1'b1;
      for (int v = 1; v <= 17; v++) begin
         check_beat($sformatf("ovf_drain_%0d", v));
         tick();
      end
      check("ovf_end_valid", W'(out_valid), W'(0));
      check("ovf_count",     W'(result_count), W'(exp_count(32'd17)));
      check("ovf_sticky",    W'(overflow), W'(8'h08));

      // Reset mid-operation with buffered results and a stalled beat.
      out_ready = 1'b0;
      in_valid  = 8'h1F;
      for (int i = 0; i < 5; i++) in_data[i] = DATA_W'(8'hF0 + i);
      tick();
      in_valid = '0;
      tick();
      tick();
      check("mid_busy", W'(drained), W'(0));
      #2;
      resetn = 1'b0;
      #1;
      check("mid_rst_valid",    W'(out_valid), W'(0));
      check("mid_rst_drained",  W'(drained),   W'(1));
      check("mid_rst_overflow", W'(overflow),  W'(0));
      check("mid_rst_count",    W'(result_count), W'(0));
      tick();
      resetn    = 1'b1;
      out_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         check($sformatf("mid_no_stale_%0d", c), W'({out_valid, drained}), W'(2'b01));
         tick();
      end
      in_valid   = 8'h80;
      in_data[7] = 128'h77;
      tick();
      in_valid = '0;
      tick();
      expect_beat(3'd7, 128'h77);
      check_beat("mid_recover");
      tick();
      check("mid_recover_drained", W'(drained), W'(1));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/join_result_merger.md
Name: join_result_merger

Overview:
Downstream stage of the partitioned hash join. It collects the eight per-partition hash-table result streams (128-bit match records, valid-only, no backpressure) and merges them into a single ready/valid output stream. Each lane has its own buffer, and lanes are served by a round-robin arbiter. The block flags results that are lost to lane overflow and reports when the whole merger is drained.

Parameters:
DATA_W, 128, width of one join result record
FIFO_DEPTH, 16, entries per lane FIFO; must be a power of two and at least 2

Ports:
clk  input  1  system clock
resetn  input  1  reset, asynchronous, active-low
in_data  input  [7:0][DATA_W-1:0]  per-lane result records from the hash tables
in_valid  input  [7:0]  per-lane valid; no ready is returned
out_data  output  DATA_W  merged result record
out_lane  output  3  lane index (partition) of out_data
out_valid  output  1  out_data/out_lane valid
out_ready  input  1  downstream accepts the beat
overflow  output  [7:0]  sticky per-lane "result dropped" flag
drained  output  1  all lane FIFOs empty and out_valid low
result_count  output  32  results delivered downstream

Behaviour:
- Single clock domain. Reset is asynchronous and active-low; clock is clk, reset is resetn.
- Reset values: out_valid=0, out_data=0, out_lane=0, overflow=0, result_count=0, drained=1. All FIFOs are emptied and the RR pointer is set to 0.
- Reset asserted mid-operation discards all buffered and in-flight results immediately. No beat is presented after resetn deasserts until new input arrives.
- Lane write: when in_valid[i]=1 at a clock edge and FIFO i is not full, the record is pushed.
- A full FIFO that is popped in the same cycle still accepts the write.
- Full with no pop: the record is dropped and overflow[i] is set. overflow is cleared only by reset.
- Arbiter: combinational. It selects the first non-empty lane scanning pointer, pointer+1, …, mod 8.
- On a grant, the pointer becomes granted+1 mod 8. With no grant, the pointer holds.
- Output register load condition: (!out_valid || out_ready) and any lane non-empty. On load, the granted FIFO is popped, out_data takes the head record, out_lane takes the lane index, and out_valid=1.
- If out_valid && out_ready and no lane is non-empty, out_valid drops to 0. out_data and out_lane hold their last value.
- While out_valid=1 and out_ready=0, out_data and out_lane stay stable and no FIFO is popped.
- Latency: a beat sampled at edge N is in its FIFO during cycle N+1, is loaded at edge N+1, and shows out_valid=1 in cycle N+2 (two cycles) when uncontended.
- Throughput: one result per cycle when out_ready=1.
- Capacity per lane is FIFO_DEPTH plus the output register when that lane's head is presented.
- Counters are pointer-based with a wrap bit: full = pointers equal with wrap bits differing; empty = pointers equal with wrap bits equal.
- drained is registered-state-derived (no combinational path from inputs) and is 1 only when all FIFOs are empty and out_valid=0.

Optional Feature:
- Macro: JOIN_MERGE_COUNT_EN
- Defined: result_count increments by 1 on every out_valid && out_ready handshake. It wraps modulo 2^32.
- Undefined: no counter logic is built and result_count is tied to 0. The port list is unchanged.

Decomposition:
- Package join_merge_pkg holds:
  - LANES=8 and LANE_IDX_W=3
  - typedef join_result_t (logic [127:0])
  - typedef lane_idx_t (logic [2:0])
- One sub-module, join_lane_fifo: a parameterised synchronous FIFO with push, pop, full, empty, and head data. It is instantiated eight times in a generate loop.
- The arbiter and output register stay in the top module.

Test Plan:
- Single beat: lane 4 pulses 0xA5 for one cycle with out_ready=1. Expected: out_valid in cycle N+2 with out_data=0xA5, out_lane=4, then drained=1. With the macro defined, result_count=1.
- Simultaneous burst: all 8 lanes pulse once with data=lane index, out_ready=1. Expected: eight consecutive beats with out_lane 0,1,…,7 and no gaps.
- Fairness: lanes 0 and 5 valid every cycle, out_ready=1. Expected: out_lane alternates 0,5,0,5 and overflow stays 0.
- Backpressure: out_ready=0 for 10 cycles with a beat present. Expected: out_data/out_lane stay stable. Raise out_ready and each beat is delivered exactly once, in order.
- Overflow: out_ready=0, lane 3 sends 18 records with FIFO_DEPTH=16. Expected: overflow[3]=1 after the 18th. Release out_ready and exactly 17 records arrive, values 1..17.
- Reset mid-operation: lanes hold 5 buffered records, then resetn is pulsed low. Expected: out_valid=0, drained=1, overflow=0, result_count=0 immediately, and no stale beats afterwards.
